// File: rtl/mux_sel_encoder_pkg.sv
// Shared types and helpers for the operand-mux select encoder.
// A lane's select code is derived from the weight's sign bit and one
// magnitude bit. A set bit picks +activation or -activation, and a clear
// bit selects the zero input of the mux.
package mux_sel_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_VEC0 = 2'b00;
    localparam sel_t SEL_VEC1 = 2'b01;
    localparam sel_t SEL_ZERO = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic sel_t encode_lane(input logic sign, input logic mag_bit);
        if (!mag_bit) begin
            return SEL_ZERO;
        end
        return sign ? SEL_VEC1 : SEL_VEC0;
    endfunction

    // Width of the bit-position field. It is kept at least one bit wide so
    // that a one-bit magnitude still gets a usable port.
    function automatic int shift_width(input int mag_w);
        return (mag_w > 1) ? $clog2(mag_w) : 1;
    endfunction

endpackage

// File: rtl/mux_sel_encoder_if.sv
// Handshake bundle between a weight source, the select encoder and the
// mux row it drives. The master modport is the side that supplies groups
// and consumes beats, and the slave modport is the encoder.
interface mux_sel_encoder_if #(
    parameter int NUM_LANE     = 8,
    parameter int WEIGHT_WIDTH = 8
);
    import mux_sel_pkg::*;

    localparam int MAG_W   = WEIGHT_WIDTH - 1;
    localparam int SHIFT_W = shift_width(MAG_W);

    logic                             in_valid;
    logic                             in_ready;
    logic [NUM_LANE*WEIGHT_WIDTH-1:0] in_weight;
    logic                             out_valid;
    logic                             out_ready;
    logic [NUM_LANE*2-1:0]            out_sel;
    logic [SHIFT_W-1:0]               out_shift;
    logic                             out_last;

    modport master (
        output in_valid, in_weight, out_ready,
        input  in_ready, out_valid, out_sel, out_shift, out_last
    );

    modport slave (
        input  in_valid, in_weight, out_ready,
        output in_ready, out_valid, out_sel, out_shift, out_last
    );

endinterface

// File: rtl/mux_sel_encoder_lead_one_detector.sv
// Priority encoder. It returns the index of the highest set bit and flags
// the case where exactly one bit is set. An empty vector reports index 0
// and single=0.
module lead_one_detector #(
    parameter int WIDTH = 7,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             single
);

    // scan upward so the highest set bit is the last one to win
    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    assign single = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/mux_sel_encoder.sv
// Serializes one group of sign-magnitude weights into per-lane mux select
// codes, one magnitude column per beat, starting with the MSB column.
//
// Build option MUX_SEL_SKIP_ZERO_COL_EN:
//   defined   - columns that are zero in every lane are skipped. A lead-one
//               detector over a column mask picks each next column. An
//               all-zero group produces a single closing beat.
//   undefined - every group walks all MAG_W columns with a down-counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no group held; in_ready=1, out_valid=0
// ST_RUN  | beat registers hold the current column; out_valid=1
module mux_sel_encoder
    import mux_sel_pkg::*;
#(
    parameter int NUM_LANE     = 8,
    parameter int WEIGHT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    mux_sel_encoder_if.slave    bus
);

    localparam int MAG_W   = WEIGHT_WIDTH - 1;
    localparam int SHIFT_W = shift_width(MAG_W);
    localparam int SEL_W   = 2 * NUM_LANE;
    localparam int GRP_W   = NUM_LANE * WEIGHT_WIDTH;
    localparam logic [SEL_W-1:0] SEL_IDLE = {NUM_LANE{SEL_ZERO}};

    state_t             state_q;
    logic               out_valid_q;
    logic               out_last_q;
    logic [SEL_W-1:0]   out_sel_q;
    logic [SHIFT_W-1:0] out_shift_q;
    logic [GRP_W-1:0]   weight_q;

    logic               beat_done;
    logic               accept;
    logic               advance;
    logic [SHIFT_W-1:0] col_next;
    logic               last_next;
    logic [GRP_W-1:0]   src_weight;
    logic [SEL_W-1:0]   sel_next;

    assign beat_done    = out_valid_q && bus.out_ready;
    // Taking a new group on the final beat's handshake avoids an idle cycle
    // between groups. This is the only combinational path through the block.
    assign bus.in_ready = (state_q == ST_IDLE) || (beat_done && out_last_q);
    assign accept       = bus.in_valid && bus.in_ready;
    assign advance      = beat_done && !out_last_q;

`ifdef MUX_SEL_SKIP_ZERO_COL_EN
    logic [MAG_W-1:0]   col_mask_q;
    logic [MAG_W-1:0]   in_mask;
    logic [MAG_W-1:0]   drop_mask;
    logic [MAG_W-1:0]   lod_in;
    logic [SHIFT_W-1:0] lod_idx;
    logic               lod_single;

    // a column is needed if any lane has that magnitude bit set
    always_comb begin
        in_mask = '0;
        for (int i = 0; i < NUM_LANE; i++) begin
            in_mask |= bus.in_weight[i*WEIGHT_WIDTH +: MAG_W];
        end
    end

    assign drop_mask = col_mask_q & ~(MAG_W'(1) << out_shift_q);
    // Loading a group and stepping through one never happen in the same
    // cycle, so a single detector serves both.
    assign lod_in    = accept ? in_mask : drop_mask;

    lead_one_detector #(
        .WIDTH (MAG_W),
        .IDX_W (SHIFT_W)
    ) u_lod (
        .vec    (lod_in),
        .idx    (lod_idx),
        .single (lod_single)
    );

    assign col_next  = lod_idx;
    // an empty mask still yields one beat, at column 0, flagged last
    assign last_next = lod_single || (lod_in == '0);

    // column mask: loaded with the group, one bit retired per beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_mask_q <= '0;
        end else if (accept) begin
            col_mask_q <= in_mask;
        end else if (advance) begin
            col_mask_q <= drop_mask;
        end else if (beat_done) begin
            col_mask_q <= '0;
        end
    end
`else
    assign col_next  = accept ? SHIFT_W'(MAG_W - 1) : (out_shift_q - SHIFT_W'(1));
    assign last_next = (col_next == '0);
`endif

    assign src_weight = accept ? bus.in_weight : weight_q;

    // select codes for the column that the next beat will present
    always_comb begin
        sel_next = SEL_IDLE;
        for (int i = 0; i < NUM_LANE; i++) begin
            sel_next[2*i +: 2] = encode_lane(src_weight[i*WEIGHT_WIDTH + WEIGHT_WIDTH - 1],
                                             src_weight[i*WEIGHT_WIDTH + int'(col_next)]);
        end
    end

    // control FSM; beat outputs are registered and change only on load or handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_sel_q   <= SEL_IDLE;
            out_shift_q <= '0;
            out_last_q  <= 1'b0;
            weight_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_RUN;
                        out_valid_q <= 1'b1;
                        weight_q    <= bus.in_weight;
                        out_sel_q   <= sel_next;
                        out_shift_q <= col_next;
                        out_last_q  <= last_next;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        out_valid_q <= 1'b1;
                        weight_q    <= bus.in_weight;
                        out_sel_q   <= sel_next;
                        out_shift_q <= col_next;
                        out_last_q  <= last_next;
                    end else if (advance) begin
                        out_sel_q   <= sel_next;
                        out_shift_q <= col_next;
                        out_last_q  <= last_next;
                    end else if (beat_done) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        out_sel_q   <= SEL_IDLE;
                        out_shift_q <= '0;
                        out_last_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_shift = out_shift_q;
    assign bus.out_last  = out_last_q;

endmodule

// File: tb/tb_mux_sel_encoder.sv
// Directed bench for mux_sel_encoder. Expected beats are queued by hand
// for whichever column mode the build selects (MUX_SEL_SKIP_ZERO_COL_EN).
`timescale 1ns/1ps
module tb_mux_sel_encoder;

    localparam int NL = 8;
    localparam int WW = 8;
    localparam logic [15:0] ALLZ = 16'hAAAA;

    typedef struct packed {
        logic [15:0] sel;
        logic [2:0]  shift;
        logic        last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_run  = 0;
    int   n_fail = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    mux_sel_encoder_if #(.NUM_LANE(NL), .WEIGHT_WIDTH(WW)) bus ();

    mux_sel_encoder #(.NUM_LANE(NL), .WEIGHT_WIDTH(WW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] s, input int sh, input logic l);
        beat_t b;
        b.sel   = s;
        b.shift = 3'(sh);
        b.last  = l;
        exp_q.push_back(b);
    endtask

    // beats of columns hi..lo that have no set magnitude bit in any lane
    task automatic push_fill(input int hi, input int lo);
        for (int c = hi; c >= lo; c--) begin
            push(ALLZ, c, c == 0);
        end
    endtask

    task automatic send(input string tag, input logic [63:0] w);
        bus.in_weight = w;
        bus.in_valid  = 1'b1;
        #1;
        check({tag, " idle_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " idle_ready"}, 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // Drain every queued beat with out_ready high. If chain is set, the next
    // group is offered during the final beat.
    task automatic consume(input string tag, input bit chain, input logic [63:0] next_w);
        beat_t e;
        bit    fin;
        int    idx;
        idx = 0;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            fin = (exp_q.size() == 0);
            bus.out_ready = 1'b1;
            if (fin && chain) begin
                bus.in_valid  = 1'b1;
                bus.in_weight = next_w;
            end
            #1;
            check($sformatf("%s[%0d] valid", tag, idx), 32'(bus.out_valid), 32'd1);
            check($sformatf("%s[%0d] sel", tag, idx),   32'(bus.out_sel),   32'(e.sel));
            check($sformatf("%s[%0d] shift", tag, idx), 32'(bus.out_shift), 32'(e.shift));
            check($sformatf("%s[%0d] last", tag, idx),  32'(bus.out_last),  32'(e.last));
            check($sformatf("%s[%0d] in_ready", tag, idx), 32'(bus.in_ready), 32'(fin));
            @(negedge clk);
            bus.in_valid = 1'b0;
            idx++;
        end
    endtask

    task automatic check_idle(input string tag);
        #1;
        check({tag, " valid"},    32'(bus.out_valid), 32'd0);
        check({tag, " in_ready"}, 32'(bus.in_ready),  32'd1);
        check({tag, " sel"},      32'(bus.out_sel),   32'(ALLZ));
        check({tag, " shift"},    32'(bus.out_shift), 32'd0);
        check({tag, " last"},     32'(bus.out_last),  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end, expected completion");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_weight = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // lane0=05, lane1=83
`ifdef MUX_SEL_SKIP_ZERO_COL_EN
        push(16'hAAA8, 2, 1'b0);
        push(16'hAAA6, 1, 1'b0);
        push(16'hAAA4, 0, 1'b1);
`else
        push_fill(6, 3);
        push(16'hAAA8, 2, 1'b0);
        push(16'hAAA6, 1, 1'b0);
        push(16'hAAA4, 0, 1'b1);
`endif
        send("colskip", 64'h0000_0000_0000_8305);
        consume("colskip", 1'b0, 64'h0);
        check_idle("colskip_end");

        // all-zero group with negative zero in lane3
`ifdef MUX_SEL_SKIP_ZERO_COL_EN
        push(ALLZ, 0, 1'b1);
`else
        push_fill(6, 0);
`endif
        send("zero", 64'h0000_0000_8000_0000);
        consume("zero", 1'b0, 64'h0);
        check_idle("zero_end");

        // backpressure on the first beat of lane0=40
        bus.out_ready = 1'b0;
        send("bp", 64'h0000_0000_0000_0040);
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("bp_hold[%0d] valid", k), 32'(bus.out_valid), 32'd1);
            check($sformatf("bp_hold[%0d] sel", k),   32'(bus.out_sel),   32'h0000AAA8);
            check($sformatf("bp_hold[%0d] shift", k), 32'(bus.out_shift), 32'd6);
`ifdef MUX_SEL_SKIP_ZERO_COL_EN
            check($sformatf("bp_hold[%0d] last", k),  32'(bus.out_last),  32'd1);
`else
            check($sformatf("bp_hold[%0d] last", k),  32'(bus.out_last),  32'd0);
`endif
            check($sformatf("bp_hold[%0d] in_ready", k), 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
`ifdef MUX_SEL_SKIP_ZERO_COL_EN
        push(16'hAAA8, 6, 1'b1);
`else
        push(16'hAAA8, 6, 1'b0);
        push_fill(5, 0);
`endif
        consume("bp", 1'b0, 64'h0);
        check_idle("bp_end");

        // back-to-back: lane0=01 then lane1=82 offered on the final beat
`ifdef MUX_SEL_SKIP_ZERO_COL_EN
        push(16'hAAA8, 0, 1'b1);
`else
        push_fill(6, 1);
        push(16'hAAA8, 0, 1'b1);
`endif
        send("b2b_a", 64'h0000_0000_0000_0001);
        consume("b2b_a", 1'b1, 64'h0000_0000_0000_8200);
`ifdef MUX_SEL_SKIP_ZERO_COL_EN
        push(16'hAAA6, 1, 1'b1);
`else
        push_fill(6, 2);
        push(16'hAAA6, 1, 1'b0);
        push(ALLZ, 0, 1'b1);
`endif
        consume("b2b_b", 1'b0, 64'h0);
        check_idle("b2b_end");

        // reset while the second beat of the 05/83 group is on the outputs
        send("rst_mid", 64'h0000_0000_0000_8305);
        bus.out_ready = 1'b1;
        #1;
`ifdef MUX_SEL_SKIP_ZERO_COL_EN
        check("rst_mid beat0 sel",   32'(bus.out_sel),   32'h0000AAA8);
        check("rst_mid beat0 shift", 32'(bus.out_shift), 32'd2);
`else
        check("rst_mid beat0 sel",   32'(bus.out_sel),   32'(ALLZ));
        check("rst_mid beat0 shift", 32'(bus.out_shift), 32'd6);
`endif
        @(negedge clk);
        rst_n = 1'b0;
        check_idle("rst_mid_async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
`ifdef MUX_SEL_SKIP_ZERO_COL_EN
        push(16'hAAA8, 0, 1'b1);
`else
        push_fill(6, 1);
        push(16'hAAA8, 0, 1'b1);
`endif
        send("post_rst", 64'h0000_0000_0000_0001);
        consume("post_rst", 1'b0, 64'h0);
        check_idle("post_rst_end");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_encoder.md
Name: mux_sel_encoder

Overview:
- Drives the select inputs of a row of 3-to-1 zero-capable operand muxes in a bit-serial PE array.
- Accepts one group of sign-magnitude weights, one per lane, and serializes it column by column, MSB magnitude bit first.
- Each beat emits a per-lane select code and the shift amount for the accumulator.
- Encoding per lane: vec[0] = +activation, vec[1] = -activation, zero = bubble.

Parameters:
- NUM_LANE, 8, number of lanes (muxes) driven in parallel.
- WEIGHT_WIDTH, 8, weight width; MSB is sign, remaining WEIGHT_WIDTH-1 bits are magnitude (MAG_W).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  weight group valid.
- in_ready  output  1  block can accept a group.
- in_weight  input  NUM_LANE*WEIGHT_WIDTH  lane i at bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH].
- out_valid  output  1  beat valid.
- out_ready  input  1  consumer accepts beat.
- out_sel  output  NUM_LANE*2  lane i select at [2i +: 2].
- out_shift  output  $clog2(MAG_W)  magnitude bit position of this beat.
- out_last  output  1  final beat of the group.

Behaviour:
- Reset: asynchronous and active-low. One clock domain (clk).
- Per-lane select codes:
  - 2'b00: magnitude bit set, sign 0.
  - 2'b01: magnitude bit set, sign 1.
  - 2'b10: magnitude bit clear.
  - 2'b11: never emitted.
- Reset values: state IDLE, out_valid=0, in_ready=1, out_sel all 2'b10, out_shift=0, out_last=0, weight and column-mask registers 0.
- FSM, two states:
  - IDLE -> RUN on in_valid&&in_ready. On that edge: capture weights; col_mask[b] = OR over lanes of magnitude bit b; current column = highest set bit of col_mask.
  - RUN: out_valid=1. out_sel, out_shift and out_last depend only on registers; no in_* to out_* combinational path.
  - On out_valid&&out_ready: clear the current bit in col_mask and advance to the next highest set bit.
  - out_last=1 when exactly one bit of col_mask remains.
  - RUN -> IDLE after the last beat handshakes, unless a new group is accepted in the same cycle. In that case stay in RUN with the new group; no bubble.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). This is the only combinational path, from out_ready to in_ready.
- Latency: the first beat is valid the cycle after input acceptance.
- Beats per group = popcount(col_mask), i.e. all-zero columns are skipped (see Optional Feature).
- Group with col_mask==0, including negative zero 8'h80: exactly one beat with all sel=2'b10, out_shift=0, out_last=1.
- Backpressure: while out_valid && !out_ready, out_sel, out_shift and out_last hold stable.
- Reset mid-group: the group is discarded; the block returns to reset values immediately.

Optional Feature:
- Macro: MUX_SEL_SKIP_ZERO_COL_EN.
- Defined: zero-column skipping as described above.
- Undefined:
  - Every group emits exactly MAG_W beats, out_shift = MAG_W-1 down to 0, with out_last on shift 0.
  - An all-zero group also emits MAG_W beats of all 2'b10.
  - The priority encoder is replaced by a down-counter.

Decomposition:
- Package mux_sel_pkg:
  - typedef logic [1:0] sel_t.
  - Constants SEL_VEC0=2'b00, SEL_VEC1=2'b01, SEL_ZERO=2'b10.
  - Function encoding one lane (sign, bit) to sel_t.
- Sub-module lead_one_detector: parameterized-width priority encoder returning the index of the highest set bit and a "single bit set" flag. Used to select the next column and to generate out_last.

Test Plan:
- Column skipping (macro defined): lane0=8'h05, lane1=8'h83, others 0, out_ready=1 -> 3 beats.
  - shift 2: lane0=00, lane1=10.
  - shift 1: lane0=10, lane1=01.
  - shift 0: lane0=00, lane1=01, last=1.
  - Other lanes 10 throughout; first beat one cycle after acceptance.
- All-zero group, including 8'h80 in lane3 -> one beat, all sel=10, shift 0, last=1; in_ready high on that handshake.
- Backpressure: lane0=8'h40, out_ready low for 3 cycles -> out_sel, out_shift=6 and out_last=1 stable and out_valid held; beat completes when out_ready rises.
- Back-to-back groups: second group presented with in_valid during the first group's last beat -> accepted that cycle; next cycle carries its first beat with no idle cycle.
- Reset mid-group: assert rst_n=0 after beat 1 of test 1 -> out_valid=0 and in_ready=1 immediately; after release, a new group 8'h01 yields a single beat, shift 0, lane0=00.
- Macro undefined: lane0=8'h01 -> 7 beats, shifts 6..0; lane0=10 except 00 at shift 0, out_last only on shift 0.
